nios2_ocimem_arbiter: RTL
=========================

# nios2_ocimem_arbiter

Arbiter and sequencer for the Nios II on-chip-instrumentation (OCI) debug RAM. It shares the single-port OCI RAM between two requesters: the JTAG debug slave's system-clock action strobes (`take_action_ocimem_*` with `jdo`), and the CPU's Avalon debug-memory slave. It sits between the debug slave wrapper and the OCI RAM. It returns JTAG read data through `MonDReg`/`monitor_ready`, and CPU read data through `avs_readdata`/`avs_waitrequest`.

## Interface
- `ADDR_W`, 8, OCI RAM word-address width (256 x 32 RAM).
- `clk`  in  1  system clock; all logic is on this edge.
- `reset`  in  1  asynchronous, active-high reset.
- `take_action_ocimem_a`  in  1  one-cycle strobe. Loads the JTAG address from `jdo[17+ADDR_W-1:17]` and clears `jtag_overrun`; if `jdo[34]`=1, also queues a JTAG read.
- `take_action_ocimem_b`  in  1  one-cycle strobe; queues a JTAG write of `jdo[34:3]` at the JTAG address.
- `take_no_action_ocimem_a`  in  1  one-cycle strobe; queues a JTAG read at the JTAG address.
- `jdo`  in  38  JTAG data-out register, valid with the strobes.
- `avs_address`  in  ADDR_W  CPU word address.
- `avs_read` / `avs_write`  in  1  CPU request; held until `avs_waitrequest`=0; never both high.
- `avs_writedata`  in  32  CPU write data.
- `avs_readdata`  out  32  CPU read data, registered.
- `avs_waitrequest`  out  1  Avalon stall.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wren`  out  1  RAM write enable.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data; 1-cycle latency from `ram_addr`.
- `MonDReg`  out  32  last JTAG read result.
- `monitor_ready`  out  1  `MonDReg` holds the result of the most recent JTAG command.
- `jtag_overrun`  out  1  sticky: a JTAG strobe arrived while a JTAG command was still pending.

## Operation
- **JTAG pending slot:** one entry holding read/write, address and data. A queueing strobe fills the slot and clears `monitor_ready`.
  - If a strobe arrives while the slot is full, the new command is dropped and `jtag_overrun` is set.
- **FSM states:** IDLE, RD_DATA, CPU_ACK.
- **IDLE:** if the JTAG slot is full and/or a CPU request is present, grant one requester.
  - On a tie, grant round-robin using the `last_grant` bit. Reset value is CPU, so JTAG wins the first tie.
  - Write grant: `ram_wren`=1 that cycle (combinational), with address and data from the granted requester.
    - For a JTAG write, the slot is freed and `monitor_ready`=1 next cycle.
    - For a CPU write, `avs_waitrequest`=0 in the grant cycle. FSM stays in IDLE.
  - Read grant: drive `ram_addr`, then go to RD_DATA.
- **RD_DATA:** capture `ram_rdata`.
  - JTAG read: capture into `MonDReg`, set `monitor_ready`, free the slot, return to IDLE.
  - CPU read: capture into `avs_readdata`, go to CPU_ACK.
- **CPU_ACK:** `avs_waitrequest`=0, then return to IDLE.
- **`avs_waitrequest`:** 1 in every cycle except a CPU write grant and CPU_ACK.
- **`ram_addr` when idle:** holds its last value; `ram_wren`=0 outside write grants.
- **Address rules:** the address wraps modulo 2^ADDR_W.
  - `take_action_ocimem_a` overwrites the JTAG address even while the slot is busy. A queued command keeps its captured address.
- **Reset values:** FSM=IDLE, slot empty, `last_grant`=CPU, JTAG address=0, `MonDReg`=0, `avs_readdata`=0, `monitor_ready`=0, `jtag_overrun`=0, `ram_wren`=0, `ram_addr`=0, `avs_waitrequest`=1.
- **Reset mid-operation:** any in-flight access is abandoned with no RAM write issued. The CPU fabric is reset together with this block.

## Timing
- **CPU write:** acknowledged in the grant cycle; zero wait states when uncontended.
- **CPU read:** grant cycle N, RD_DATA at N+1, `avs_waitrequest`=0 and `avs_readdata` valid at N+2.
- **JTAG write:** strobe at cycle S, earliest grant S+1, `monitor_ready` at S+2.
- **JTAG read:** strobe at cycle S, earliest grant S+1, `MonDReg`/`monitor_ready` valid at S+3.
- **Worst-case extra wait for either requester:** one full opposite access, at most 3 cycles.

## Configuration
- `OCIMEM_AUTOINC_EN` defined: after each granted JTAG access, the JTAG address increments by 1, wrapping.
  - An increment coinciding with `take_action_ocimem_a` loses; the load wins.
- Undefined: the JTAG address changes only on `take_action_ocimem_a`.

## Structure
- **Shared package `nios2_ocimem_pkg`:**
  - FSM state enum.
  - Grant-source enum (CPU/JTAG).
  - `jdo` field constants: address LSB 17, read flag bit 34, write data bits [34:3].
- **Sub-module `nios2_ocimem_jtag_slot`:** the pending slot, address register, overrun flag and auto-increment. It presents valid/rd/addr/data to the arbiter FSM.

## Test plan
- **Reset:** during and after reset, `avs_waitrequest`=1, `monitor_ready`=0, `MonDReg`=0, `ram_wren`=0.
- **CPU alone:** write 0xDEADBEEF @0x10 acks in the grant cycle. A read @0x10 then returns 0xDEADBEEF with `avs_waitrequest` low exactly 2 cycles after grant.
- **JTAG alone:** `ocimem_a` with addr 0x20, then `ocimem_b` with data 0x12345678, then `ocimem_a` with `jdo[34]`=1 @0x20. Result: `MonDReg`=0x12345678, `monitor_ready`=1.
- **Simultaneous:** JTAG read and CPU read in the same cycle. Grant order is JTAG first, then CPU, with the CPU ack at +5 cycles. A repeat tie then grants CPU first.
- **Overrun:** a second JTAG strobe while the slot is busy sets `jtag_overrun` and the second command is not executed. A following `ocimem_a` clears `jtag_overrun`.
- **With `OCIMEM_AUTOINC_EN`:** from address 0xFF, three `take_no_action_ocimem_a` strobes read 0xFF, 0x00, 0x01.

Source files
------------

// File: rtl/nios2_ocimem_pkg.sv
// Shared definitions for the Nios II OCI debug-RAM arbiter.
//   state_t  : arbiter FSM states
//   grant_t  : grant source (CPU / JTAG)
//   JDO_*    : field positions inside the 38-bit JTAG data-out register
package nios2_ocimem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_DATA = 2'd1,
        ST_CPU_ACK = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_CPU  = 1'b0,
        GRANT_JTAG = 1'b1
    } grant_t;

    localparam int unsigned JDO_W         = 38;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned JDO_ADDR_LSB  = 17;
    localparam int unsigned JDO_RD_BIT    = 34;
    localparam int unsigned JDO_WDATA_LSB = 3;

endpackage

// File: rtl/nios2_ocimem_jtag_slot.sv
// JTAG side of the OCI debug-RAM arbiter: address register, single-entry
// pending command slot, monitor_ready and sticky overrun flag.
// Optional feature: define OCIMEM_AUTOINC_EN to post-increment the JTAG
// address after every granted JTAG access.
// Ports:
//   clk, reset                 system clock, async active-high reset
//   take_action_ocimem_a/_b,
//   take_no_action_ocimem_a    one-cycle JTAG action strobes
//   jdo                        JTAG data-out register
//   grant                      arbiter granted the pending JTAG command
//   done                       pending JTAG command retired this cycle
//   valid/rd/addr/data         pending command presented to the arbiter
//   monitor_ready              MonDReg holds the latest command's result
//   jtag_overrun               sticky: command dropped because slot was full
module nios2_ocimem_jtag_slot
    import nios2_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              grant,
    input  logic              done,
    output logic              valid,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              monitor_ready,
    output logic              jtag_overrun
);

    logic [ADDR_W-1:0] jtag_addr;
    logic [ADDR_W-1:0] jdo_addr;
    logic [DATA_W-1:0] jdo_wdata;
    logic              queue_rd_a;
    logic              queue;

    always_comb begin
        jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
        jdo_wdata  = jdo[JDO_WDATA_LSB +: DATA_W];
        queue_rd_a = take_action_ocimem_a & jdo[JDO_RD_BIT];
        queue      = queue_rd_a | take_action_ocimem_b | take_no_action_ocimem_a;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jtag_addr     <= '0;
            valid         <= 1'b0;
            rd            <= 1'b0;
            addr          <= '0;
            data          <= '0;
            monitor_ready <= 1'b0;
            jtag_overrun  <= 1'b0;
        end else begin
            // Address load beats the auto-increment.
            if (take_action_ocimem_a) begin
                jtag_addr <= jdo_addr;
            end
`ifdef OCIMEM_AUTOINC_EN
            else if (grant) begin
                jtag_addr <= jtag_addr + ADDR_W'(1);
            end
`endif

            // A dropped command sets the flag even if the same strobe
            // would otherwise clear it.
            if (queue && valid) begin
                jtag_overrun <= 1'b1;
            end else if (take_action_ocimem_a) begin
                jtag_overrun <= 1'b0;
            end

            // The slot is still full in its retire cycle, so done and an
            // accepted fill never coincide.
            if (done) begin
                valid         <= 1'b0;
                monitor_ready <= 1'b1;
            end else if (queue && !valid) begin
                valid         <= 1'b1;
                monitor_ready <= 1'b0;
                if (queue_rd_a) begin
                    rd   <= 1'b1;
                    addr <= jdo_addr;
                end else if (take_action_ocimem_b) begin
                    rd   <= 1'b0;
                    addr <= jtag_addr;
                    data <= jdo_wdata;
                end else begin
                    rd   <= 1'b1;
                    addr <= jtag_addr;
                end
            end
        end
    end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Arbiter/sequencer sharing the single-port OCI debug RAM between the JTAG
// debug slave (action strobes + jdo) and the CPU Avalon debug-memory slave.
// Optional feature: OCIMEM_AUTOINC_EN (JTAG address auto-increment, see
// nios2_ocimem_jtag_slot).
// Ports:
//   clk, reset                  system clock, async active-high reset
//   take_action_ocimem_a/_b,
//   take_no_action_ocimem_a, jdo JTAG command interface
//   avs_*                       CPU Avalon slave (read/write/waitrequest)
//   ram_addr/ram_wren/ram_wdata/ram_rdata  OCI RAM port (1-cycle read)
//   MonDReg, monitor_ready      JTAG read result and its valid flag
//   jtag_overrun                sticky JTAG overrun flag
module nios2_ocimem_arbiter
    import nios2_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [JDO_W-1:0]  jdo,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun
);

    state_t            state;
    grant_t            last_grant;
    grant_t            owner;
    logic [ADDR_W-1:0] addr_q;

    logic              slot_valid;
    logic              slot_rd;
    logic [ADDR_W-1:0] slot_addr;
    logic [DATA_W-1:0] slot_data;
    logic              slot_done;

    logic              cpu_req;
    logic              pick_jtag;
    logic              jtag_grant;
    logic              cpu_grant;

    nios2_ocimem_jtag_slot #(.ADDR_W(ADDR_W)) u_slot (
        .clk                     (clk),
        .reset                   (reset),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .grant                   (jtag_grant),
        .done                    (slot_done),
        .valid                   (slot_valid),
        .rd                      (slot_rd),
        .addr                    (slot_addr),
        .data                    (slot_data),
        .monitor_ready           (monitor_ready),
        .jtag_overrun            (jtag_overrun)
    );

    always_comb begin
        cpu_req    = avs_read | avs_write;
        // Grants are suppressed while reset is asserted so no RAM write can
        // leak out of an abandoned access.
        pick_jtag  = slot_valid && (!cpu_req || last_grant == GRANT_CPU);
        jtag_grant = (state == ST_IDLE) && !reset && pick_jtag;
        cpu_grant  = (state == ST_IDLE) && !reset && cpu_req && !pick_jtag;

        ram_addr  = addr_q;
        ram_wren  = 1'b0;
        ram_wdata = '0;
        if (jtag_grant) begin
            ram_addr  = slot_addr;
            ram_wren  = !slot_rd;
            ram_wdata = slot_data;
        end else if (cpu_grant) begin
            ram_addr  = avs_address;
            ram_wren  = avs_write;
            ram_wdata = avs_writedata;
        end

        avs_waitrequest = !((cpu_grant && avs_write) || state == ST_CPU_ACK);
        slot_done       = (jtag_grant && !slot_rd) ||
                          (state == ST_RD_DATA && owner == GRANT_JTAG);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            last_grant   <= GRANT_CPU;
            owner        <= GRANT_CPU;
            addr_q       <= '0;
            MonDReg      <= '0;
            avs_readdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (jtag_grant || cpu_grant) begin
                        addr_q <= ram_addr;
                        owner  <= jtag_grant ? GRANT_JTAG : GRANT_CPU;
                        // Round-robin state only advances on contested
                        // grants, so an uncontested access does not steal
                        // the other side's turn at the next tie.
                        if (slot_valid && cpu_req) begin
                            last_grant <= jtag_grant ? GRANT_JTAG : GRANT_CPU;
                        end
                        if (jtag_grant ? slot_rd : avs_read) begin
                            state <= ST_RD_DATA;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (owner == GRANT_JTAG) begin
                        MonDReg <= ram_rdata;
                        state   <= ST_IDLE;
                    end else begin
                        avs_readdata <= ram_rdata;
                        state        <= ST_CPU_ACK;
                    end
                end
                ST_CPU_ACK: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

endmodule
